// File: rtl/cc_pkg.sv
// -----------------------------------------------------------------------------
// cc_pkg
// Shared definitions for the cache-controller miss path: AXI burst constants
// for a 64-byte line fetched as 8 x 8-byte beats, the address field positions
// of the line, and the miss-request scheduler state encoding.
// -----------------------------------------------------------------------------
package cc_pkg;

    // AXI AR constants for one line refill
    localparam logic [3:0] CC_AXI_LEN_LINE   = 4'd7;   // 8 beats
    localparam logic [2:0] CC_AXI_SIZE_8B    = 3'd3;   // 8 bytes per beat
    localparam logic [1:0] CC_AXI_BURST_WRAP = 2'b10;  // critical word first

    // Address field positions
    localparam int CC_OFFSET_MSB = 5;
    localparam int CC_OFFSET_LSB = 3;
    localparam int CC_INDEX_MSB  = 14;
    localparam int CC_INDEX_LSB  = 6;
    localparam int CC_TAG_MSB    = 31;
    localparam int CC_TAG_LSB    = 15;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } cc_mreq_state_e;

    // Beat-aligned start address of a wrap burst: the word holding the
    // missing byte is fetched first.
    function automatic logic [31:0] cc_beat_addr(input logic [31:0] addr);
        return {addr[31:CC_OFFSET_LSB], 3'b000};
    endfunction

endpackage

// File: rtl/cc_outstanding_ctr.sv
// -----------------------------------------------------------------------------
// cc_outstanding_ctr
// Saturating up/down counter of AXI read bursts in flight.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   inc            one burst issued (AR handshake)
//   dec            one burst completed (rlast beat)
//   count          current number of outstanding bursts
//   at_max         count has reached MAX_OUTSTANDING
// -----------------------------------------------------------------------------
module cc_outstanding_ctr
    import cc_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             at_max
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Simultaneous inc and dec cancel; both directions saturate.
    always_comb begin
        count_d = count_q;
        if (inc && !dec && (count_q != MAX_C)) begin
            count_d = count_q + CNT_W'(1);
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            // rready is held low at zero, so a completion here is a protocol bug
            assert (!(dec && (count_q == '0)));
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign at_max = (count_q >= MAX_C);

endmodule

// File: rtl/cc_miss_req_scheduler.sv
// -----------------------------------------------------------------------------
// cc_miss_req_scheduler
// Turns each accepted line miss into one 8-beat critical-word-first WRAP burst
// on the AXI AR channel and pushes the full miss address into the miss-address
// FIFO at the AR handshake, so FIFO order matches R-data order. Tracks bursts
// in flight, drives R readiness and throttles misses at the outstanding limit
// or when the FIFO is full.
//
// Optional build macro CC_MISS_MERGE_EN: a miss to the line of the most
// recently issued, still outstanding burst is acknowledged without a new
// burst (no AR, no FIFO push, no count change).
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   miss_valid_i/addr_i/ready_o miss request handshake from tag compare
//   mem_ar*                    AXI read-address channel (ARID fixed at 0)
//   mem_rvalid_i/rlast_i/rready_o  AXI read-data handshake and burst end
//   miss_addr_fifo_*           miss-address FIFO full flag and push port
//   busy_o                     bursts outstanding or AR pending
// -----------------------------------------------------------------------------
module cc_miss_req_scheduler
    import cc_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        miss_valid_i,
    input  logic [31:0] miss_addr_i,
    output logic        miss_ready_o,
    output logic        mem_arvalid_o,
    input  logic        mem_arready_i,
    output logic [31:0] mem_araddr_o,
    output logic [3:0]  mem_arlen_o,
    output logic [2:0]  mem_arsize_o,
    output logic [1:0]  mem_arburst_o,
    input  logic        mem_rvalid_i,
    input  logic        mem_rlast_i,
    output logic        mem_rready_o,
    input  logic        miss_addr_fifo_full_i,
    output logic        miss_addr_fifo_wren_o,
    output logic [31:0] miss_addr_fifo_wdata_o,
    output logic        busy_o
);

    cc_mreq_state_e   state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [CNT_W-1:0] out_cnt;
    logic             at_max;
    logic             ar_hs;
    logic             burst_done;
    logic             issue_ready;
    logic             merge_hit;
    logic             issue_accept;

    cc_outstanding_ctr #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (ar_hs),
        .dec    (burst_done),
        .count  (out_cnt),
        .at_max (at_max)
    );

    assign ar_hs        = mem_arvalid_o & mem_arready_i;
    assign mem_rready_o = (out_cnt != '0);
    assign burst_done   = mem_rvalid_i & mem_rready_o & mem_rlast_i;

`ifdef CC_MISS_MERGE_EN
    logic [31:CC_INDEX_LSB] last_line_q, last_line_d;
    logic                   last_line_vld_q, last_line_vld_d;

    assign merge_hit = (state_q == IDLE) && (out_cnt != '0) && last_line_vld_q &&
                       (miss_addr_i[31:CC_INDEX_LSB] == last_line_q);

    // Remember the line of the newest burst; forget it once nothing is in
    // flight, since no pending fill can then satisfy a merged miss.
    always_comb begin
        last_line_d     = last_line_q;
        last_line_vld_d = last_line_vld_q;
        if (ar_hs) begin
            last_line_d     = addr_q[31:CC_INDEX_LSB];
            last_line_vld_d = 1'b1;
        end else if (out_cnt == '0) begin
            last_line_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_line_q     <= '0;
            last_line_vld_q <= 1'b0;
        end else begin
            last_line_q     <= last_line_d;
            last_line_vld_q <= last_line_vld_d;
        end
    end
`else
    assign merge_hit = 1'b0;
`endif

    // Gated with rst_n so no miss is ever acknowledged while in reset.
    assign issue_ready  = rst_n && (state_q == IDLE) && !at_max && !miss_addr_fifo_full_i;
    assign miss_ready_o = issue_ready | (rst_n & merge_hit);
    assign issue_accept = miss_valid_i & issue_ready & !merge_hit;

    always_comb begin
        state_d                = state_q;
        addr_d                 = addr_q;
        mem_arvalid_o          = 1'b0;
        miss_addr_fifo_wren_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (issue_accept) begin
                    addr_d  = miss_addr_i;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mem_arvalid_o = 1'b1;
                if (mem_arready_i) begin
                    miss_addr_fifo_wren_o = 1'b1;
                    state_d               = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    assign mem_araddr_o           = cc_beat_addr(addr_q);
    assign mem_arlen_o            = CC_AXI_LEN_LINE;
    assign mem_arsize_o           = CC_AXI_SIZE_8B;
    assign mem_arburst_o          = CC_AXI_BURST_WRAP;
    assign miss_addr_fifo_wdata_o = addr_q;
    assign busy_o                 = (out_cnt != '0) || (state_q == ISSUE);

endmodule

// File: tb/tb_cc_miss_req_scheduler.sv
// -----------------------------------------------------------------------------
// tb_cc_miss_req_scheduler
// Directed bench for cc_miss_req_scheduler (MAX_OUTSTANDING = 2). Inputs are
// driven on the falling edge; outputs are sampled 1 ns later, mid-cycle.
// -----------------------------------------------------------------------------
module tb_cc_miss_req_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_valid_i;
    logic [31:0] miss_addr_i;
    logic        miss_ready_o;
    logic        mem_arvalid_o;
    logic        mem_arready_i;
    logic [31:0] mem_araddr_o;
    logic [3:0]  mem_arlen_o;
    logic [2:0]  mem_arsize_o;
    logic [1:0]  mem_arburst_o;
    logic        mem_rvalid_i;
    logic        mem_rlast_i;
    logic        mem_rready_o;
    logic        miss_addr_fifo_full_i;
    logic        miss_addr_fifo_wren_o;
    logic [31:0] miss_addr_fifo_wdata_o;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cc_miss_req_scheduler #(
        .MAX_OUTSTANDING (2),
        .CNT_W           (3)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .miss_valid_i           (miss_valid_i),
        .miss_addr_i            (miss_addr_i),
        .miss_ready_o           (miss_ready_o),
        .mem_arvalid_o          (mem_arvalid_o),
        .mem_arready_i          (mem_arready_i),
        .mem_araddr_o           (mem_araddr_o),
        .mem_arlen_o            (mem_arlen_o),
        .mem_arsize_o           (mem_arsize_o),
        .mem_arburst_o          (mem_arburst_o),
        .mem_rvalid_i           (mem_rvalid_i),
        .mem_rlast_i            (mem_rlast_i),
        .mem_rready_o           (mem_rready_o),
        .miss_addr_fifo_full_i  (miss_addr_fifo_full_i),
        .miss_addr_fifo_wren_o  (miss_addr_fifo_wren_o),
        .miss_addr_fifo_wdata_o (miss_addr_fifo_wdata_o),
        .busy_o                 (busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One cycle: apply inputs at the falling edge, settle 1 ns.
    task automatic drive(input logic mv, input logic [31:0] ma, input logic arr,
                         input logic rv, input logic rl, input logic full);
        @(negedge clk);
        miss_valid_i          = mv;
        miss_addr_i           = ma;
        mem_arready_i         = arr;
        mem_rvalid_i          = rv;
        mem_rlast_i           = rl;
        miss_addr_fifo_full_i = full;
        #1;
    endtask

    initial begin
        rst_n                 = 1'b0;
        miss_valid_i          = 1'b0;
        miss_addr_i           = '0;
        mem_arready_i         = 1'b0;
        mem_rvalid_i          = 1'b0;
        mem_rlast_i           = 1'b0;
        miss_addr_fifo_full_i = 1'b0;

        // ---- reset state ----
        #12;
        chk("rst_miss_ready", miss_ready_o, 0);
        chk("rst_arvalid",    mem_arvalid_o, 0);
        chk("rst_wren",       miss_addr_fifo_wren_o, 0);
        chk("rst_rready",     mem_rready_o, 0);
        chk("rst_busy",       busy_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- single miss, arready high ----
        drive(1, 32'h0001_2348, 1, 0, 0, 0);
        chk("t1_ready_N",    miss_ready_o, 1);
        chk("t1_arvalid_N",  mem_arvalid_o, 0);
        drive(0, 32'h0, 1, 0, 0, 0);
        chk("t1_arvalid",    mem_arvalid_o, 1);
        chk("t1_araddr",     mem_araddr_o, 32'h0001_2348);
        chk("t1_arlen",      mem_arlen_o, 7);
        chk("t1_arsize",     mem_arsize_o, 3);
        chk("t1_arburst",    mem_arburst_o, 2);
        chk("t1_wren",       miss_addr_fifo_wren_o, 1);
        chk("t1_wdata",      miss_addr_fifo_wdata_o, 32'h0001_2348);
        chk("t1_ready_issue", miss_ready_o, 0);
        drive(0, 32'h0, 0, 0, 0, 0);
        chk("t1_arvalid_off", mem_arvalid_o, 0);
        chk("t1_wren_off",   miss_addr_fifo_wren_o, 0);
        chk("t1_rready",     mem_rready_o, 1);
        chk("t1_busy",       busy_o, 1);
        for (int i = 0; i < 7; i++) begin
            drive(0, 32'h0, 0, 1, 0, 0);
            chk("t1_rready_beat", mem_rready_o, 1);
        end
        drive(0, 32'h0, 0, 1, 1, 0);
        chk("t1_rready_last", mem_rready_o, 1);
        drive(0, 32'h0, 0, 0, 0, 0);
        chk("t1_rready_done", mem_rready_o, 0);
        chk("t1_busy_done",  busy_o, 0);

        // ---- arready low for 5 cycles ----
        drive(1, 32'h0000_ABCD, 0, 0, 0, 0);
        chk("t2_ready", miss_ready_o, 1);
        for (int i = 0; i < 5; i++) begin
            drive(0, 32'h0, 0, 0, 0, 0);
            chk("t2_arvalid_hold", mem_arvalid_o, 1);
            chk("t2_araddr_hold",  mem_araddr_o, 32'h0000_ABC8);
            chk("t2_wren_wait",    miss_addr_fifo_wren_o, 0);
        end
        drive(0, 32'h0, 1, 0, 0, 0);
        chk("t2_wren",  miss_addr_fifo_wren_o, 1);
        chk("t2_wdata", miss_addr_fifo_wdata_o, 32'h0000_ABCD);
        drive(0, 32'h0, 1, 0, 0, 0);
        chk("t2_wren_once", miss_addr_fifo_wren_o, 0);
        drive(0, 32'h0, 0, 1, 1, 0);
        drive(0, 32'h0, 0, 0, 0, 0);
        chk("t2_busy_done", busy_o, 0);

        // ---- three back-to-back misses, limit 2, then coincident AR/rlast ----
        drive(1, 32'h0000_0100, 1, 0, 0, 0);
        chk("t3_ready_a", miss_ready_o, 1);
        drive(1, 32'h0000_0200, 1, 0, 0, 0);
        chk("t3_ready_issue_a", miss_ready_o, 0);
        chk("t3_araddr_a", mem_araddr_o, 32'h0000_0100);
        drive(1, 32'h0000_0200, 1, 0, 0, 0);
        chk("t3_ready_b", miss_ready_o, 1);
        drive(1, 32'h0000_0300, 1, 0, 0, 0);
        chk("t3_araddr_b", mem_araddr_o, 32'h0000_0200);
        chk("t3_wren_b",   miss_addr_fifo_wren_o, 1);
        drive(1, 32'h0000_0300, 1, 0, 0, 0);
        chk("t3_ready_full1", miss_ready_o, 0);
        chk("t3_arvalid_none1", mem_arvalid_o, 0);
        drive(1, 32'h0000_0300, 1, 0, 0, 0);
        chk("t3_ready_full2", miss_ready_o, 0);
        drive(1, 32'h0000_0300, 1, 1, 1, 0);
        chk("t3_ready_at_rlast", miss_ready_o, 0);
        drive(1, 32'h0000_0300, 1, 0, 0, 0);
        chk("t3_ready_c", miss_ready_o, 1);
        // AR handshake of the third burst coincides with an rlast beat
        drive(0, 32'h0, 1, 1, 1, 0);
        chk("t3_arvalid_c", mem_arvalid_o, 1);
        chk("t3_araddr_c",  mem_araddr_o, 32'h0000_0300);
        chk("t3_wren_c",    miss_addr_fifo_wren_o, 1);
        drive(0, 32'h0, 0, 0, 0, 0);
        chk("t4_rready_cnt1", mem_rready_o, 1);
        chk("t4_ready_cnt1",  miss_ready_o, 1);
        drive(0, 32'h0, 0, 1, 1, 0);
        drive(0, 32'h0, 0, 0, 0, 0);
        chk("t4_rready_drained", mem_rready_o, 0);
        chk("t4_busy_drained",   busy_o, 0);

        // ---- FIFO full at out_cnt = 0 ----
        drive(1, 32'h0000_4000, 1, 0, 0, 1);
        chk("t5_ready_full1", miss_ready_o, 0);
        drive(1, 32'h0000_4000, 1, 0, 0, 1);
        chk("t5_ready_full2", miss_ready_o, 0);
        chk("t5_arvalid_none", mem_arvalid_o, 0);
        drive(1, 32'h0000_4000, 1, 0, 0, 0);
        chk("t5_ready_release", miss_ready_o, 1);
        drive(0, 32'h0, 1, 0, 0, 0);
        chk("t5_arvalid", mem_arvalid_o, 1);
        chk("t5_araddr",  mem_araddr_o, 32'h0000_4000);
        drive(0, 32'h0, 0, 1, 1, 0);
        drive(0, 32'h0, 0, 0, 0, 0);
        chk("t5_busy_done", busy_o, 0);

        // ---- same-line miss while outstanding ----
        drive(1, 32'h0000_1040, 1, 0, 0, 0);
        drive(0, 32'h0, 1, 0, 0, 0);
        chk("t6_wdata_first", miss_addr_fifo_wdata_o, 32'h0000_1040);
        drive(1, 32'h0000_1078, 1, 0, 0, 0);
        chk("t6_ready_same_line", miss_ready_o, 1);
        drive(0, 32'h0, 1, 0, 0, 0);
`ifdef CC_MISS_MERGE_EN
        chk("t6_merge_no_ar",   mem_arvalid_o, 0);
        chk("t6_merge_no_push", miss_addr_fifo_wren_o, 0);
        drive(0, 32'h0, 0, 1, 1, 0);
        drive(0, 32'h0, 0, 0, 0, 0);
        chk("t6_merge_busy_after_one", busy_o, 0);
`else
        chk("t6_second_ar",    mem_arvalid_o, 1);
        chk("t6_second_push",  miss_addr_fifo_wren_o, 1);
        chk("t6_second_wdata", miss_addr_fifo_wdata_o, 32'h0000_1078);
        chk("t6_second_araddr", mem_araddr_o, 32'h0000_1078);
        drive(0, 32'h0, 0, 1, 1, 0);
        drive(0, 32'h0, 0, 0, 0, 0);
        chk("t6_busy_after_one", busy_o, 1);
        drive(0, 32'h0, 0, 1, 1, 0);
        drive(0, 32'h0, 0, 0, 0, 0);
        chk("t6_busy_after_two", busy_o, 0);
`endif

        // ---- asynchronous reset mid-operation ----
        drive(1, 32'h0000_2000, 0, 0, 0, 0);
        drive(0, 32'h0, 0, 0, 0, 0);
        chk("t7_arvalid_pre", mem_arvalid_o, 1);
        rst_n = 1'b0;
        #1;
        chk("t7_arvalid_rst", mem_arvalid_o, 0);
        chk("t7_busy_rst",    busy_o, 0);
        chk("t7_ready_rst",   miss_ready_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cc_miss_req_scheduler.md
# cc_miss_req_scheduler

Sequences cache-miss refills between the cache controller's tag-compare stage and the memory AXI read channel. Each line miss is turned into one 8-beat, critical-word-first wrap burst on AR, and the miss address is pushed into the miss-address FIFO that the data fill unit pops. The block counts outstanding bursts and drives R-channel readiness. It throttles new misses when the outstanding limit or the FIFO is full.

## Interface
Parameters:
- MAX_OUTSTANDING, default 2: maximum AR bursts in flight (1..7).
- CNT_W, default 3: width of the outstanding counter; must hold MAX_OUTSTANDING.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- miss_valid_i  in  1  miss request from tag compare.
- miss_addr_i  in  32  byte address of the missing access.
- miss_ready_o  out  1  miss accepted this cycle when high together with miss_valid_i.
- mem_arvalid_o  out  1  AXI AR valid.
- mem_arready_i  in  1  AXI AR ready.
- mem_araddr_o  out  32  {miss_addr[31:3], 3'b000}, critical word first.
- mem_arlen_o  out  4  constant 4'd7.
- mem_arsize_o  out  3  constant 3'd3 (8 bytes).
- mem_arburst_o  out  2  constant 2'b10 (WRAP).
- mem_rvalid_i  in  1  AXI R valid.
- mem_rlast_i  in  1  AXI R last.
- mem_rready_o  out  1  AXI R ready.
- miss_addr_fifo_full_i  in  1  miss-address FIFO full.
- miss_addr_fifo_wren_o  out  1  FIFO push.
- miss_addr_fifo_wdata_o  out  32  full 32-bit miss address; the fill unit needs it to extract index, tag and offset.
- busy_o  out  1  outstanding count non-zero, or in ISSUE state.

## Operation
- States: IDLE, ISSUE.
- IDLE:
  - miss_ready_o = (out_cnt < MAX_OUTSTANDING) & !miss_addr_fifo_full_i.
  - On miss_valid_i & miss_ready_o: latch miss_addr_i into addr_q and go to ISSUE.
- ISSUE:
  - mem_arvalid_o = 1, mem_araddr_o from addr_q; the address is held stable while waiting.
  - On mem_arready_i: pulse miss_addr_fifo_wren_o with wdata = addr_q in the same cycle, out_cnt +1, return to IDLE.
  - miss_ready_o = 0.
- mem_rready_o = (out_cnt != 0).
- R-beat handshake = mem_rvalid_i & mem_rready_o.
- Burst completion = R-beat handshake & mem_rlast_i; out_cnt -1.
- Same cycle AR handshake and burst completion: out_cnt unchanged.
- out_cnt never wraps. The AR handshake is only possible when acceptance already checked out_cnt < MAX. A completion at out_cnt == 0 cannot occur (rready is 0); assert in simulation.
- The FIFO push happens at AR handshake, so FIFO order equals AR order equals R order. AXI returns read bursts in order for a single ID; ARID is fixed at 0 and not a port.
- FIFO overflow is impossible: full was sampled at acceptance, and this block is the only writer. The fill unit pops only on the first R beat, so the FIFO level is at most out_cnt.

## Timing
- Reset values: miss_ready_o 0 during reset; mem_arvalid_o 0, miss_addr_fifo_wren_o 0, mem_rready_o 0, busy_o 0, state IDLE, out_cnt 0, addr_q 0.
- miss_ready_o is combinational from registered state, out_cnt and the FIFO full input. It does not depend on miss_valid_i.
- Acceptance at cycle N: mem_arvalid_o high from N+1. With arready already high, the AR handshake and FIFO push occur at N+1, and the next miss can be accepted at N+2.
- Minimum spacing between bursts is 2 cycles.
- mem_arvalid_o never drops before its handshake, except on reset.
- Reset asserted mid-operation: all state clears immediately and asynchronously; outstanding bursts are discarded. The system resets memory and FIFO together.

## Configuration
- CC_MISS_MERGE_EN.
- Defined:
  - Keep last_line_q = addr_q[31:6] of the most recent issued burst.
  - In IDLE, when out_cnt != 0 and miss_addr_i[31:6] == last_line_q, accept the miss: miss_ready_o is high even at the MAX/FIFO-full limits.
  - A merged miss is acknowledged without AR, FIFO push or count change; the pending fill will satisfy it.
  - last_line_q is cleared to invalid when out_cnt reaches 0.
- Undefined: every accepted miss issues its own burst; no comparator is built.

## Structure
- Shared package cc_pkg holds:
  - AXI constants CC_AXI_LEN_LINE = 4'd7, CC_AXI_SIZE_8B = 3'd3, CC_AXI_BURST_WRAP = 2'b10.
  - Field positions: OFFSET [5:3], INDEX [14:6], TAG [31:15].
  - State enum typedef cc_mreq_state_e {IDLE, ISSUE}.
- One natural sub-module, cc_outstanding_ctr: saturating up/down counter with inc, dec, count and at_max outputs.

## Test plan
- Single miss at 0x0001_2348 with arready held high:
  - ready at N; araddr 0x0001_2348, arlen 7, arburst 2'b10 at N+1; FIFO push of 0x0001_2348 at N+1.
  - rready high until the rlast beat; busy_o low after it.
- arready low for 5 cycles: arvalid and araddr stay stable across all 5 cycles; exactly one FIFO push, on the arready cycle.
- Three back-to-back misses with MAX_OUTSTANDING = 2 and no R traffic: two AR handshakes, then miss_ready_o stays 0 until the first rlast beat. The third AR issues after that beat.
- AR handshake coincident with an rlast beat at out_cnt = 1: out_cnt stays 1 and rready stays high.
- miss_addr_fifo_full_i = 1 while out_cnt = 0: miss_ready_o stays 0; release full, accept next cycle.
- With CC_MISS_MERGE_EN: issue 0x0000_1040, then while outstanding present 0x0000_1078 (same line). Required: accepted, no AR, no FIFO push, out_cnt unchanged. Without the macro the same stimulus yields two bursts.
